// File: rtl/serdes_tx_arbiter.sv
// serdes_tx_arbiter
//   Round-robin arbiter and sequencer that shares one parallel-to-serial
//   serializer between NREQ requesters. A requester is granted for a burst of
//   at most BURST_LEN bytes. Bytes go to the serializer through a single
//   registered output stage (ser_data_o / ser_valid_o / ser_id_o).
//
// Parameters
//   NREQ      number of requesters (2..8)
//   DW        data width per byte
//   BURST_LEN max bytes per grant (1..15)
//   IW        id width, clog2(NREQ)
//
// Ports
//   pclk_i       parallel clock, rising edge
//   rst_i        asynchronous active-low reset
//   req_data_i   requester n data at [n*DW +: DW]
//   req_valid_i  per-requester valid
//   req_ready_o  per-requester ready, at most one bit high
//   ser_data_o   registered byte to serializer
//   ser_valid_o  registered byte valid
//   ser_ready_i  serializer accepts byte
//   ser_id_o     source requester of ser_data_o
//   grant_o      one-hot grant, zero in IDLE
//   busy_o       high in XFER or while ser_valid_o is high
//
// Configuration
//   SERDES_ARB_PRIO_EN : requester 0 wins every IDLE arbitration it takes part
//   in; the others rotate round-robin and the pointer never rests on 0.

module serdes_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int BURST_LEN = 4,
    parameter int IW        = 2
) (
    input  logic                 pclk_i,
    input  logic                 rst_i,
    input  logic [NREQ*DW-1:0]   req_data_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic [DW-1:0]        ser_data_o,
    output logic                 ser_valid_o,
    input  logic                 ser_ready_i,
    output logic [IW-1:0]        ser_id_o,
    output logic [NREQ-1:0]      grant_o,
    output logic                 busy_o
);

    localparam int CW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IW-1:0]           r_gidx;
    logic [IW-1:0]           r_ptr;
    logic [CW-1:0]           r_cnt;
    logic [DW-1:0]           r_data;
    logic                    r_valid;
    logic [IW-1:0]           r_id;

    logic [NREQ-1:0][DW-1:0] w_lane_data;
    logic                    w_free;
    logic                    w_gvalid;
    logic                    w_load;
    logic                    w_release;
    logic                    w_found;
    logic [IW-1:0]           w_pick;
    logic [IW-1:0]           w_ptr_nxt;
    logic [CW-1:0]           w_cnt_inc;

    genvar n;
    generate
        for (n = 0; n < NREQ; n++) begin : g_lane
            assign w_lane_data[n] = req_data_i[n*DW +: DW];
        end
    endgenerate

    // Output stage can take a byte if empty or draining this edge.
    assign w_free    = ~r_valid | ser_ready_i;
    assign w_gvalid  = req_valid_i[r_gidx];
    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_load    = (r_state == XFER) & w_gvalid & w_free;
    // A stall (w_free low) never releases: only the burst limit or a dropped
    // valid ends the grant.
    assign w_release = (r_state == XFER) &
                       (~w_gvalid | (w_load & (w_cnt_inc == CW'(BURST_LEN))));

    // First valid requester at or above the pointer, wrapping.
    always_comb begin
        logic [IW:0] idx;
        w_found = 1'b0;
        w_pick  = '0;
        idx     = '0;
`ifdef SERDES_ARB_PRIO_EN
        if (req_valid_i[0]) w_found = 1'b1;
`endif
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, r_ptr} + (IW+1)'(i);
            if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
`ifdef SERDES_ARB_PRIO_EN
            if (!w_found && (idx != '0) && req_valid_i[idx[IW-1:0]]) begin
`else
            if (!w_found && req_valid_i[idx[IW-1:0]]) begin
`endif
                w_found = 1'b1;
                w_pick  = idx[IW-1:0];
            end
        end
    end

    // Pointer after releasing the current grant.
    always_comb begin
        logic [IW:0] p;
        p = {1'b0, r_gidx} + (IW+1)'(1);
        if (p >= (IW+1)'(NREQ)) p = '0;
`ifdef SERDES_ARB_PRIO_EN
        if (p == '0) p = (IW+1)'(1);
`endif
        w_ptr_nxt = p[IW-1:0];
    end

    always_ff @(posedge pclk_i or negedge rst_i) begin
        if (!rst_i) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = '0;
        grant_o     = '0;
        case (r_state)
            IDLE: begin
                if (w_found) w_state_nxt = XFER;
            end
            XFER: begin
                req_ready_o[r_gidx] = w_free;
                grant_o[r_gidx]     = 1'b1;
                if (w_release) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_gidx  <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_id    <= '0;
        end else begin
            if (r_state == IDLE) begin
                r_cnt <= '0;
                if (w_found) r_gidx <= w_pick;
            end else begin
                if (w_load)    r_cnt <= w_cnt_inc;
                if (w_release) r_ptr <= w_ptr_nxt;
            end
            // A load in the same edge as a drain replaces the byte, no bubble.
            if (w_load) begin
                r_data  <= w_lane_data[r_gidx];
                r_id    <= r_gidx;
                r_valid <= 1'b1;
            end else if (ser_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign ser_data_o  = r_data;
    assign ser_valid_o = r_valid;
    assign ser_id_o    = r_id;
    assign busy_o      = (r_state == XFER) | r_valid;

endmodule

// File: tb/tb_serdes_tx_arbiter.sv
// Self-checking bench for serdes_tx_arbiter (default parameters).
// A transaction-level model predicts outputs every cycle; directed tests add
// hand-computed expectations on grant order, byte order and spacing.
module tb_serdes_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int BL   = 4;
    localparam int IW   = 2;

    logic                pclk;
    logic                rst_i;
    logic [NREQ*DW-1:0]  req_data_i;
    logic [NREQ-1:0]     req_valid_i;
    logic [NREQ-1:0]     req_ready_o;
    logic [DW-1:0]       ser_data_o;
    logic                ser_valid_o;
    logic                ser_ready_i;
    logic [IW-1:0]       ser_id_o;
    logic [NREQ-1:0]     grant_o;
    logic                busy_o;

    serdes_tx_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_LEN(BL), .IW(IW)) dut (
        .pclk_i(pclk), .rst_i(rst_i), .req_data_i(req_data_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .ser_data_o(ser_data_o), .ser_valid_o(ser_valid_o),
        .ser_ready_i(ser_ready_i), .ser_id_o(ser_id_o),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [7:0]      src [NREQ][$];
    logic [NREQ-1:0] xf = '0;
    int              lg_id[$];
    int              lg_data[$];
    int              lg_cyc[$];
    int              gr_log[$];
    int              prev_g = 0;

    // model state: m_g = -1 means no grant
    int m_g = -1, m_ptr = 0, m_cnt = 0, m_data = 0, m_id = 0;
    bit m_valid = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int m_pick(input logic [NREQ-1:0] v, input int ptr);
        int c;
`ifdef SERDES_ARB_PRIO_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            c = (ptr + k) % NREQ;
`ifdef SERDES_ARB_PRIO_EN
            if (c == 0) continue;
`endif
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic int m_next_ptr(input int g);
        int p;
        p = (g + 1) % NREQ;
`ifdef SERDES_ARB_PRIO_EN
        if (p == 0) p = 1;
`endif
        return p;
    endfunction

    initial forever @(posedge pclk) cyc++;

    // Monitor: log, compare against model, then advance model one edge.
    initial forever begin
        @(negedge pclk);
        if (!rst_i) begin
            m_g = -1; m_ptr = 0; m_cnt = 0; m_data = 0; m_id = 0; m_valid = 1'b0;
        end else begin
            if (ser_valid_o && ser_ready_i) begin
                lg_id.push_back(int'(ser_id_o));
                lg_data.push_back(int'(ser_data_o));
                lg_cyc.push_back(cyc);
            end
            if (grant_o != 0 && int'(grant_o) != prev_g) gr_log.push_back(int'(grant_o));
        end
        prev_g = int'(grant_o);
        if (cyc >= 1) begin
            bit free;
            free = !m_valid || ser_ready_i;
            chk("ready", int'(req_ready_o), (m_g >= 0 && free) ? (1 << m_g) : 0);
            chk("grant", int'(grant_o), (m_g >= 0) ? (1 << m_g) : 0);
            chk("busy", int'(busy_o), (m_g >= 0 || m_valid) ? 1 : 0);
            chk("ser_valid", int'(ser_valid_o), int'(m_valid));
            if (m_valid) begin
                chk("ser_data", int'(ser_data_o), m_data);
                chk("ser_id", int'(ser_id_o), m_id);
            end
        end
        if (rst_i) begin
            if (m_g < 0) begin
                if (m_valid && ser_ready_i) m_valid = 1'b0;
                m_g   = m_pick(req_valid_i, m_ptr);
                m_cnt = 0;
            end else begin
                bit take, stop;
                take = req_valid_i[m_g] && (!m_valid || ser_ready_i);
                stop = !req_valid_i[m_g];
                if (take) begin
                    m_data  = int'(req_data_i[m_g*DW +: DW]);
                    m_id    = m_g;
                    m_valid = 1'b1;
                    m_cnt++;
                    stop = (m_cnt == BL);
                end else if (m_valid && ser_ready_i) begin
                    m_valid = 1'b0;
                end
                if (stop) begin
                    m_ptr = m_next_ptr(m_g);
                    m_g   = -1;
                end
            end
        end
        xf = req_valid_i & req_ready_o;
    end

    // One clock: pop bytes that transferred, present the next ones.
    task automatic tick();
        @(posedge pclk);
        #1;
        for (int n = 0; n < NREQ; n++) begin
            if (xf[n] && src[n].size() > 0) void'(src[n].pop_front());
            req_valid_i[n] = (src[n].size() > 0);
            req_data_i[n*DW +: DW] = (src[n].size() > 0) ? src[n][0] : 8'h00;
        end
    endtask

    task automatic run(input int k);
        repeat (k) tick();
    endtask

    task automatic clr_logs();
        lg_id.delete(); lg_data.delete(); lg_cyc.delete(); gr_log.delete();
    endtask

    task automatic clr_src();
        for (int n = 0; n < NREQ; n++) src[n].delete();
        req_valid_i = '0;
        req_data_i  = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        clr_src();
        tick();
        tick();
        rst_i = 1'b1;
        clr_logs();
    endtask

    task automatic wait_bytes(input int k, input string nm);
        int b;
        b = 0;
        while (lg_id.size() < k && b < 40) begin
            tick();
            b++;
        end
        if (lg_id.size() < k) chk({nm, "_timeout"}, lg_id.size(), k);
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_ready"}, int'(req_ready_o), 0);
        chk({nm, "_grant"}, int'(grant_o), 0);
        chk({nm, "_valid"}, int'(ser_valid_o), 0);
        chk({nm, "_data"}, int'(ser_data_o), 0);
        chk({nm, "_id"}, int'(ser_id_o), 0);
        chk({nm, "_busy"}, int'(busy_o), 0);
    endtask

    initial begin
        int t0, held, gp;
        int ord[8];
        int kid[NREQ];
        rst_i = 1'b0; ser_ready_i = 1'b1; req_valid_i = '0; req_data_i = '0;
        tick(); tick();
        chk_zero_outputs("reset");
        rst_i = 1'b1;
        clr_logs();
        tick();

        // T1: requester 2 sends A5, 3C then drops valid
        src[2].push_back(8'hA5); src[2].push_back(8'h3C);
        tick();
        t0 = cyc;
        run(15);
        chk("t1_nbytes", lg_id.size(), 2);
        if (lg_id.size() == 2) begin
            chk("t1_b0", lg_data[0], 8'hA5);
            chk("t1_b1", lg_data[1], 8'h3C);
            chk("t1_id0", lg_id[0], 2);
            chk("t1_id1", lg_id[1], 2);
            chk("t1_latency", lg_cyc[0] - t0, 2);
            chk("t1_b2b", lg_cyc[1] - lg_cyc[0], 1);
        end
        chk("t1_ngrant", gr_log.size(), 1);
        if (gr_log.size() == 1) chk("t1_grant", gr_log[0], 4'b0100);
        chk("t1_idle_grant", int'(grant_o), 0);

        // T1b: pointer now 3 -> requester 3 before 0 (prio: 0 first)
        clr_logs();
        src[0].push_back(8'h11); src[3].push_back(8'h33);
        run(15);
        chk("t1b_ngrant", gr_log.size(), 2);
        if (gr_log.size() == 2) begin
`ifdef SERDES_ARB_PRIO_EN
            chk("t1b_g0", gr_log[0], 4'b0001);
            chk("t1b_g1", gr_log[1], 4'b1000);
`else
            chk("t1b_g0", gr_log[0], 4'b1000);
            chk("t1b_g1", gr_log[1], 4'b0001);
`endif
        end

        // T2: all four continuously valid, 8 bytes each
        do_reset();
`ifdef SERDES_ARB_PRIO_EN
        ord = '{0, 0, 1, 2, 3, 1, 2, 3};
`else
        ord = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        for (int n = 0; n < NREQ; n++) begin
            kid[n] = 0;
            for (int k = 0; k < 8; k++) src[n].push_back(8'(n*16 + k));
        end
        run(60);
        chk("t2_nbytes", lg_id.size(), 32);
        chk("t2_ngrant", gr_log.size(), 8);
        if (gr_log.size() == 8)
            for (int j = 0; j < 8; j++) chk("t2_grant", gr_log[j], 1 << ord[j]);
        if (lg_id.size() == 32) begin
            for (int i = 0; i < 32; i++) begin
                chk("t2_id", lg_id[i], ord[i/4]);
                chk("t2_data", lg_data[i], ord[i/4]*16 + kid[ord[i/4]]);
                kid[ord[i/4]]++;
                if (i > 0) begin
                    gp = (i % 4 == 0) ? 2 : 1;
                    chk("t2_gap", lg_cyc[i] - lg_cyc[i-1], gp);
                end
            end
        end

        // T3: requester 1 with a 5-cycle serializer stall
        do_reset();
        for (int k = 0; k < 6; k++) src[1].push_back(8'(8'h10 + k));
        tick();
        wait_bytes(2, "t3");
        ser_ready_i = 1'b0;
        held = int'(ser_data_o);
        chk("t3_held_val", held, 8'h12);
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("t3_hold_data", int'(ser_data_o), held);
            chk("t3_hold_valid", int'(ser_valid_o), 1);
            chk("t3_hold_ready", int'(req_ready_o[1]), 0);
            chk("t3_hold_grant", int'(grant_o), 4'b0010);
        end
        ser_ready_i = 1'b1;
        run(25);
        chk("t3_nbytes", lg_id.size(), 6);
        if (lg_id.size() == 6)
            for (int i = 0; i < 6; i++) begin
                chk("t3_data", lg_data[i], 8'h10 + i);
                chk("t3_id", lg_id[i], 1);
            end

        // T4: reset in the middle of a burst, then requester 3
        do_reset();
        for (int k = 0; k < 4; k++) src[0].push_back(8'(8'h20 + k));
        tick();
        wait_bytes(2, "t4");
        #2;
        rst_i = 1'b0;
        #1;
        chk_zero_outputs("t4_rst");
        clr_src();
        tick();
        rst_i = 1'b1;
        clr_logs();
        for (int k = 0; k < 5; k++) src[3].push_back(8'(8'h30 + k));
        run(25);
        chk("t4_nbytes", lg_id.size(), 5);
        if (lg_id.size() == 5)
            for (int i = 0; i < 5; i++) begin
                chk("t4_data", lg_data[i], 8'h30 + i);
                chk("t4_id", lg_id[i], 3);
                if (i > 0) chk("t4_gap", lg_cyc[i] - lg_cyc[i-1], (i == 4) ? 2 : 1);
            end
        chk("t4_ngrant", gr_log.size(), 2);

        // T5: pointer at 2, requesters 0 and 2 valid
        do_reset();
        src[1].push_back(8'h41);
        run(10);
        clr_logs();
        src[0].push_back(8'h50); src[0].push_back(8'h51);
        src[2].push_back(8'h60); src[2].push_back(8'h61);
        run(20);
        chk("t5_ngrant", gr_log.size(), 2);
        chk("t5_nbytes", lg_id.size(), 4);
        if (gr_log.size() == 2 && lg_id.size() == 4) begin
`ifdef SERDES_ARB_PRIO_EN
            chk("t5_g0", gr_log[0], 4'b0001);
            chk("t5_g1", gr_log[1], 4'b0100);
            chk("t5_first", lg_data[0], 8'h50);
            chk("t5_third", lg_data[2], 8'h60);
`else
            chk("t5_g0", gr_log[0], 4'b0100);
            chk("t5_g1", gr_log[1], 4'b0001);
            chk("t5_first", lg_data[0], 8'h60);
            chk("t5_third", lg_data[2], 8'h50);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
